// File: rtl/uart_transmitter_pkg.sv
// uart_package: shared UART types, register layout and LCR bit positions
package uart_package;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2, TIMEOUT} codec_state_t;
  typedef struct packed {
    codec_state_t state;
    logic [2:0]   bit_cnt;
  } u_codec_t;
  typedef struct packed {
    logic [7:0] baud_reg;
    logic [6:0] lcr;
  } u_reg_t;
  localparam int LCR_WLS = 0;
  localparam int LCR_STB = 2;
  localparam int LCR_PEN = 3;
  localparam int LCR_EPS = 4;
  localparam int LCR_SP  = 5;
  localparam int LCR_BC  = 6;
endpackage

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: show-ahead TX FIFO read handshake between FIFO and transmitter
interface uart_transmitter_if;
  logic       tx_fifo_empty;
  logic [7:0] tx_fifo_rdata;
  logic       tx_fifo_pop;
  modport master (output tx_fifo_empty, tx_fifo_rdata, input tx_fifo_pop);
  modport slave (input tx_fifo_empty, tx_fifo_rdata, output tx_fifo_pop);
endinterface

// File: rtl/uart_transmitter_parity.sv
// uart_parity_gen: parity over the 5..8 transmitted data bits, upper bits masked
module uart_parity_gen (
  input  logic [7:0] data_i,
  input  logic [1:0] wls_i,
  input  logic       pen_i,
  input  logic       eps_i,
  input  logic       stick_i,
  output logic       par_o
);
  logic [7:0] mask;
  logic       x;
  assign mask  = 8'hFF >> (2'd3 - wls_i);
  assign x     = ^(data_i & mask);
  assign par_o = pen_i & (stick_i ? ~eps_i : (eps_i ? x : ~x));
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: pops TX FIFO bytes and serializes them as framed characters on txd
module uart_transmitter
  import uart_package::*;
(
  input  logic              clk_i,
  input  logic              nrst_i,
  input  u_reg_t            u_reg,
  input  logic              trans_clk_en,
  uart_transmitter_if.slave fifo,
  output u_codec_t          trans_codec,
  output logic              txd,
  output logic              tsr_empty
);
  codec_state_t state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [7:0]   shift_q, shift_d, data_q, data_d;
  logic [5:0]   frame_q, frame_d;
  logic [10:0]  half_q, half_d;
  logic         txd_q, txd_d, tsr_q;
  logic         pop_w, par_w;
  assign pop_w            = (state_q == IDLE) && !fifo.tx_fifo_empty;
  assign fifo.tx_fifo_pop = pop_w;
  uart_parity_gen u_par (
    .data_i  (data_q),
    .wls_i   (frame_q[LCR_WLS +: 2]),
    .pen_i   (frame_q[LCR_PEN]),
    .eps_i   (frame_q[LCR_EPS]),
    .stick_i (frame_q[LCR_SP]),
    .par_o   (par_w)
  );
  // next frame state; txd is derived from the next state so the line is registered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    frame_d = frame_q;
    half_d  = '0;
    case (state_q)
      IDLE: if (pop_w) begin
        state_d = START;
        shift_d = fifo.tx_fifo_rdata;
        data_d  = fifo.tx_fifo_rdata;
        frame_d = u_reg.lcr[5:0];
      end
      START: if (trans_clk_en) begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: if (trans_clk_en) begin
        shift_d = {1'b0, shift_q[7:1]};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == {1'b1, frame_q[LCR_WLS +: 2]}) state_d = frame_q[LCR_PEN] ? PARITY : STOP;
      end
      PARITY: if (trans_clk_en) state_d = STOP;
      STOP: if (trans_clk_en) state_d = frame_q[LCR_STB] ? STOP2 : IDLE;
      STOP2: if (frame_q[LCR_WLS +: 2] == 2'b00) begin
        half_d = (half_q == {u_reg.baud_reg, 3'b111}) ? '0 : half_q + 11'd1;
        if (half_q == {u_reg.baud_reg, 3'b111}) state_d = IDLE;
      end else if (trans_clk_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    txd_d = u_reg.lcr[LCR_BC] ? 1'b0 :
            (state_d == START)  ? 1'b0 :
            (state_d == DATA)   ? shift_d[0] :
            (state_d == PARITY) ? par_w : 1'b1;
  end
  // state and registered line outputs
  always_ff @(posedge clk_i or negedge nrst_i)
    if (!nrst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      frame_q <= '0;
      half_q  <= '0;
      txd_q   <= 1'b1;
      tsr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      frame_q <= frame_d;
      half_q  <= half_d;
      txd_q   <= txd_d;
      tsr_q   <= (state_d == IDLE);
    end
  assign trans_codec = '{state: state_q, bit_cnt: cnt_q};
  assign txd         = txd_q;
  assign tsr_empty   = tsr_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: per-cycle waveform model plus literal framing checks
module tb_uart_transmitter;
  import uart_package::*;
  logic     clk = 1'b0;
  logic     nrst_i;
  u_reg_t   u_reg;
  logic     trans_clk_en;
  u_codec_t trans_codec;
  logic     txd, tsr_empty;
  uart_transmitter_if fifo ();
  uart_transmitter dut (
    .clk_i        (clk),
    .nrst_i       (nrst_i),
    .u_reg        (u_reg),
    .trans_clk_en (trans_clk_en),
    .fifo         (fifo),
    .trans_codec  (trans_codec),
    .txd          (txd),
    .tsr_empty    (tsr_empty)
  );
  always #5 clk = ~clk;
  int         n_chk, n_fail, cyc, div;
  logic [7:0] fq[$];
  bit         wave[$];
  bit         brk_prev;
  logic [6:0] lcr_n;
  logic [7:0] baud_n;
  int         pop_cyc[$];
  bit         txd_h[int];
  bit         tsr_h[int];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask
  // expected line levels of one whole frame, one entry per clock cycle
  function automatic void build(logic [7:0] d, logic [6:0] l, logic [7:0] b);
    int n, wl, ones;
    bit p;
    n = 16 * (int'(b) + 1);
    wl = 5 + int'(l[1:0]);
    ones = 0;
    repeat (n) wave.push_back(1'b0);
    for (int i = 0; i < wl; i++) begin
      ones += int'(d[i]);
      repeat (n) wave.push_back(d[i]);
    end
    if (l[3]) begin
      p = l[5] ? !l[4] : (l[4] ? bit'(ones % 2) : !bit'(ones % 2));
      repeat (n) wave.push_back(p);
    end
    repeat (n) wave.push_back(1'b1);
    if (l[2]) repeat (wl == 5 ? n / 2 : n) wave.push_back(1'b1);
  endfunction
  task automatic step();
    bit idle, exp_pop;
    int n;
    @(negedge clk);
    n = 16 * (int'(baud_n) + 1);
    u_reg.lcr = lcr_n;
    u_reg.baud_reg = baud_n;
    fifo.tx_fifo_empty = (fq.size() == 0);
    fifo.tx_fifo_rdata = (fq.size() > 0) ? fq[0] : 8'h00;
    trans_clk_en = (trans_codec.state != IDLE) && (div == n - 1);
    #1;
    idle = (wave.size() == 0);
    exp_pop = idle && (fq.size() > 0);
    chk("txd", txd, brk_prev ? 0 : (idle ? 1 : wave[0]));
    chk("tsr_empty", tsr_empty, idle);
    chk("pop", fifo.tx_fifo_pop, exp_pop);
    chk("state_idle", trans_codec.state == IDLE, idle);
    txd_h[cyc] = txd;
    tsr_h[cyc] = tsr_empty;
    if (fifo.tx_fifo_pop) pop_cyc.push_back(cyc);
    if (exp_pop) build(fq[0], lcr_n, baud_n);
    else if (!idle) void'(wave.pop_front());
    if (fifo.tx_fifo_pop && fq.size() > 0) void'(fq.pop_front());
    brk_prev = lcr_n[6];
    div = (trans_codec.state == IDLE || div == n - 1) ? 0 : div + 1;
    cyc++;
  endtask
  task automatic frame(logic [7:0] d, output int p);
    int c0, n0;
    c0 = cyc;
    n0 = pop_cyc.size();
    p = c0;
    fq.push_back(d);
    for (int i = 0; i < 4 && pop_cyc.size() == n0; i++) step();
    chk("pop_seen", pop_cyc.size() - n0, 1);
    if (pop_cyc.size() > n0) p = pop_cyc[n0];
    chk("pop_latency", p - c0, 0);
  endtask
  int p, p0, c, hi;
  int seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  initial begin
    nrst_i = 1'b0;
    lcr_n = 7'h03;
    baud_n = 8'd0;
    u_reg.lcr = lcr_n;
    u_reg.baud_reg = baud_n;
    fifo.tx_fifo_empty = 1'b1;
    fifo.tx_fifo_rdata = 8'h00;
    trans_clk_en = 1'b0;
    #12;
    chk("rst_txd", txd, 1);
    chk("rst_tsr", tsr_empty, 1);
    chk("rst_pop", fifo.tx_fifo_pop, 0);
    chk("rst_state", trans_codec.state, IDLE);
    chk("rst_bitcnt", trans_codec.bit_cnt, 0);
    #1 nrst_i = 1'b1;
    repeat (3) step();
    frame(8'hA5, p);
    repeat (170) step();
    for (int k = 0; k < 10; k++) chk("8n1_bit", txd_h[p + 1 + 16 * k + 8], seq[k]);
    chk("8n1_tsr_busy", tsr_h[p + 160], 0);
    chk("8n1_tsr_rise", tsr_h[p + 161], 1);
    lcr_n = 7'h1A;
    frame(8'h41, p);
    repeat (165) step();
    chk("7e1_parity", txd_h[p + 1 + 16 * 8 + 8], 0);
    lcr_n = 7'h0A;
    frame(8'h41, p);
    repeat (165) step();
    chk("7o1_parity", txd_h[p + 1 + 16 * 8 + 8], 1);
    lcr_n = 7'h3B;
    frame(8'h41, p);
    repeat (180) step();
    chk("stick0_parity", txd_h[p + 1 + 16 * 9 + 8], 0);
    lcr_n = 7'h2B;
    frame(8'h41, p);
    repeat (180) step();
    chk("stick1_parity", txd_h[p + 1 + 16 * 9 + 8], 1);
    lcr_n = 7'h04;
    baud_n = 8'd1;
    frame(8'h1F, p);
    repeat (245) step();
    chk("s15_start_end", txd_h[p + 32], 0);
    hi = 0;
    for (int k = p + 193; k <= p + 240; k++) hi += int'(txd_h[k]);
    chk("s15_stop_high", hi, 48);
    chk("s15_tsr_busy", tsr_h[p + 240], 0);
    chk("s15_tsr_rise", tsr_h[p + 241], 1);
    baud_n = 8'd0;
    lcr_n = 7'h03;
    fq.push_back(8'h11);
    fq.push_back(8'h22);
    frame(8'h33, p0);
    repeat (2 * 161 + 170) step();
    chk("b2b_pops", pop_cyc.size() >= 3 ? pop_cyc[$] - pop_cyc[$ - 2] : 0, 322);
    chk("b2b_gap", pop_cyc.size() >= 3 ? pop_cyc[$ - 1] - pop_cyc[$ - 2] : 0, 161);
    chk("b2b_idle_txd", txd_h[p0 + 161], 1);
    chk("b2b_idle_tsr", tsr_h[p0 + 161], 1);
    chk("b2b_next_start", txd_h[p0 + 162], 0);
    fq.push_back(8'hFF);
    frame(8'hFF, p0);
    repeat (40) step();
    lcr_n = 7'h43;
    c = cyc;
    step();
    step();
    chk("brk_before", txd_h[c], 1);
    chk("brk_after", txd_h[c + 1], 0);
    repeat (200) step();
    chk("brk_pop_sched", pop_cyc[$] - p0, 161);
    lcr_n = 7'h03;
    repeat (170) step();
    frame(8'h55, p);
    repeat (40) step();
    #1 nrst_i = 1'b0;
    #1;
    chk("arst_txd", txd, 1);
    chk("arst_state", trans_codec.state, IDLE);
    chk("arst_tsr", tsr_empty, 1);
    wave.delete();
    div = 0;
    #1 nrst_i = 1'b1;
    repeat (5) step();
    frame(8'h01, p);
    repeat (165) step();
    chk("rst_restart_s0", txd_h[p + 1], 0);
    chk("rst_restart_s15", txd_h[p + 16], 0);
    chk("rst_restart_d0", txd_h[p + 17], 1);
    chk("rst_restart_end", tsr_h[p + 161], 1);
    for (int i = 0; i < 25; i++) begin
      baud_n = 8'($urandom_range(0, 1));
      lcr_n = {1'b0, 6'($urandom_range(0, 63))};
      repeat ($urandom_range(1, 2)) fq.push_back(8'($urandom));
      for (int k = 0; k < 5000 && (wave.size() > 0 || fq.size() > 0); k++) begin
        if ($urandom_range(0, 63) == 0) lcr_n[5:0] = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 127) == 0) lcr_n[6] = ~lcr_n[6];
        step();
      end
      chk("rand_drain", wave.size() + fq.size(), 0);
      lcr_n[6] = 1'b0;
      repeat (2) step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
